pkt_meta_gen: RTL
=================

Name: pkt_meta_gen

Overview:
- Sits directly upstream of the parser stage. Consumes the raw 512-bit Avalon-ST packet stream from the ingress path.
- Forwards packet flits unchanged to the parser packet port.
- Generates exactly one metadata token per packet on a separate stream, which feeds the parser meta port.
- Token contents: packet id, byte length, flit count, SOP timestamp, error flags. The two outputs stay packet-aligned: the Nth meta token describes the Nth forwarded packet.

Parameters:
- DATA_W, 512, packet data width in bits; bytes per flit = DATA_W/8.
- EMPTY_W, 6, width of empty field (log2 of DATA_W/8).
- META_DEPTH, 8, meta FIFO depth in tokens; power of two, minimum 2.
- LEN_W, 16, byte-length field width.

Ports:
- Clk  in  1  clock
- Rst_n  in  1  reset, asynchronous assert, active-low
- in_pkt_data  in  DATA_W  ingress flit
- in_pkt_valid  in  1  ingress valid
- in_pkt_ready  out  1  ingress ready
- in_pkt_sop  in  1  start of packet
- in_pkt_eop  in  1  end of packet
- in_pkt_empty  in  EMPTY_W  unused bytes in EOP flit
- out_pkt_data  out  DATA_W  flit to parser
- out_pkt_valid  out  1
- out_pkt_ready  in  1
- out_pkt_sop  out  1
- out_pkt_eop  out  1
- out_pkt_empty  out  EMPTY_W
- out_meta_data  out  $bits(pmg_meta_t)  meta token to parser
- out_meta_valid  out  1
- out_meta_ready  in  1
- stats_pkt  out  32  packets completed
- stats_drop_flit  out  32  flits dropped (no SOP while idle)

Behaviour:
- Reset: all valids 0, in_pkt_ready 0, FSM IDLE, counters/timestamp/pkt_id 0, FIFO empty.
- Handshakes:
  - A transfer occurs on valid & ready, on both inputs and outputs.
  - out_*_valid, once high, holds with stable data until the matching ready.
- Packet path:
  - Two-entry skid buffer, registered outputs; latency 1 cycle.
  - in_pkt_ready = skid buffer not full AND meta FIFO has ≥1 free slot. The free-slot term guarantees an EOP is never accepted without space for its token.
- Timestamp: 32-bit free-running counter, wraps at 2^32; incremented every cycle after reset.
- FSM, evaluated on each accepted ingress flit:
  - IDLE, flit with sop: capture ts and pkt_id; flit_cnt = 1; forward flit.
    - If eop is also set: single-flit packet; push token; stay IDLE.
    - Otherwise go to IN_PKT.
  - IDLE, flit without sop: drop the flit (do not forward); stats_drop_flit++.
  - IN_PKT, flit without sop: flit_cnt++ (saturates at 1023); forward.
    - If eop: push token; go to IDLE.
  - IN_PKT, flit with sop (missing EOP):
    - Push a token for the previous packet with trunc=1 and length = flit_cnt*DATA_W/8.
    - Start a new packet on the same flit. The forwarded stream is passed as-is; the parser sees the malformed framing.
    - FIFO space check applies unchanged; worst case is one push per cycle.
- Length computation: len = flit_cnt*(DATA_W/8) − empty, computed at LEN_W+1 bits. If the result exceeds 2^LEN_W−1, len = all-ones and oversize = 1.
- Counters:
  - pkt_id increments by 1 per pushed token and wraps at 2^16.
  - stats_pkt increments per pushed token.
  - Both stats counters wrap at 2^32.
- Meta FIFO:
  - Depth META_DEPTH, first-word-fall-through.
  - A push and a pop in the same cycle while full is legal; occupancy is unchanged.
  - out_meta_valid = FIFO not empty.
- Output stalls: out_pkt_ready low for any time with meta still draining (or vice versa) causes no loss; backpressure propagates to in_pkt_ready.
- Reset mid-packet: FSM returns to IDLE and the FIFO and skid buffer are flushed. The first post-reset flit without SOP is dropped and counted.

Decomposition:
- Shared package pmg_pkg:
  - pmg_meta_t packed struct: pkt_id[15:0], len[LEN_W-1:0], flits[9:0], ts[31:0], trunc, oversize.
  - FSM enum {IDLE, IN_PKT}.
  - BYTES_PER_FLIT constant.
- One natural sub-module: pmg_sync_fifo (parameterised width/depth, FWFT, full/empty/count), used for the meta FIFO. The skid buffer stays inline.

Test Plan:
- Single-flit packet (sop=eop=1, empty=20) at cycle 10 after reset: out_pkt flit at cycle 11; token len=44, flits=1, pkt_id=0, trunc=0.
- 3-flit packet (empty=0) then 2-flit packet (empty=63): tokens len=192/pkt_id=0, then len=65/pkt_id=1; stats_pkt=2.
- Flit without SOP while IDLE: not forwarded; stats_drop_flit=1; no token generated.
- SOP at flit 3 of an open packet: token trunc=1, len=128, flits=2; the new packet completes normally with its own token.
- out_meta_ready=0 across 8 one-flit packets: FIFO fills, in_pkt_ready drops after the 8th EOP. Raise ready: tokens pkt_id 0..7 in order; no flit loss.
- 1100-flit packet: flits=1023 (saturated), len=0xFFFF, oversize=1.

Source files
------------

// File: rtl/pmg_pkg.sv
// pmg_pkg: shared types and constants for the packet metadata generator.
//   pmg_meta_t  - metadata token (pkt_id, len, flits, ts, trunc, oversize)
//   pmg_state_e - packet-framing FSM states
//   BYTES_PER_FLIT, FLIT_CNT_W - default flit geometry and flit-count width
package pmg_pkg;

   localparam int PMG_DATA_W     = 512;
   localparam int PMG_LEN_W      = 16;
   localparam int BYTES_PER_FLIT = PMG_DATA_W / 8;
   localparam int FLIT_CNT_W     = 10;

   localparam logic [FLIT_CNT_W-1:0] FLIT_CNT_MAX = '1;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } pmg_state_e;

   typedef struct packed {
      logic [15:0]            pkt_id;
      logic [PMG_LEN_W-1:0]   len;
      logic [FLIT_CNT_W-1:0]  flits;
      logic [31:0]            ts;
      logic                   trunc;
      logic                   oversize;
   } pmg_meta_t;

endpackage

// File: rtl/pmg_sync_fifo.sv
// pmg_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n        - clock, asynchronous active-low reset (flushes pointers)
//   wr_en_i/wr_data_i - push; accepted when not full, or when full with a pop
//   rd_en_i/rd_data_o - pop; rd_data_o shows the head entry while not empty
//   full_o, empty_o, count_o - occupancy status
module pmg_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_ok, rd_ok;

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign wr_ok = wr_en_i & (~full_o | rd_en_i);
   assign rd_ok = rd_en_i & ~empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);

endmodule

// File: rtl/pkt_meta_gen.sv
// pkt_meta_gen: forwards an Avalon-ST packet stream to the parser and emits
// one metadata token per packet on a separate FWFT stream.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_pkt_*             - ingress flit stream (data/valid/ready/sop/eop/empty)
//   out_pkt_*            - forwarded flit stream, 1-cycle latency via skid buffer
//   out_meta_*           - metadata token stream (pmg_meta_t)
//   stats_pkt            - tokens pushed (packets completed or truncated)
//   stats_drop_flit      - non-SOP flits discarded while idle
module pkt_meta_gen
   import pmg_pkg::*;
#(
   parameter int DATA_W     = PMG_DATA_W,
   parameter int EMPTY_W    = 6,
   parameter int META_DEPTH = 8,
   parameter int LEN_W      = PMG_LEN_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DATA_W-1:0]  in_pkt_data,
   input  logic               in_pkt_valid,
   output logic               in_pkt_ready,
   input  logic               in_pkt_sop,
   input  logic               in_pkt_eop,
   input  logic [EMPTY_W-1:0] in_pkt_empty,
   output logic [DATA_W-1:0]  out_pkt_data,
   output logic               out_pkt_valid,
   input  logic               out_pkt_ready,
   output logic               out_pkt_sop,
   output logic               out_pkt_eop,
   output logic [EMPTY_W-1:0] out_pkt_empty,
   output pmg_meta_t          out_meta_data,
   output logic               out_meta_valid,
   input  logic               out_meta_ready,
   output logic [31:0]        stats_pkt,
   output logic [31:0]        stats_drop_flit
);

   localparam int BPF = DATA_W / 8;
   localparam int FW  = DATA_W + EMPTY_W + 2;
   localparam int MAW = $clog2(META_DEPTH);

   typedef logic [LEN_W:0] acc_t;

   // Byte accumulator step; saturates so a long packet cannot wrap back
   // into the legal length range.
   function automatic acc_t add_flit_bytes(input acc_t a);
      logic [LEN_W+1:0] s;
      s = {1'b0, a} + (LEN_W+2)'(BPF);
      return s[LEN_W+1] ? '1 : s[LEN_W:0];
   endfunction

   // Returns {oversize, len}: anything above the LEN_W range clamps to all-ones.
   function automatic acc_t sat_len(input acc_t bytes, input logic [EMPTY_W-1:0] empty);
      acc_t r;
      r = bytes - (LEN_W+1)'(empty);
      return r[LEN_W] ? '1 : r;
   endfunction

   function automatic pmg_meta_t make_tok(input acc_t bytes, input logic [EMPTY_W-1:0] empty,
                                          input logic [FLIT_CNT_W-1:0] flits,
                                          input logic [31:0] ts, input logic trunc);
      pmg_meta_t t;
      acc_t      l;
      l          = sat_len(bytes, empty);
      t.pkt_id   = '0;
      t.len      = l[LEN_W-1:0];
      t.flits    = flits;
      t.ts       = ts;
      t.trunc    = trunc;
      t.oversize = l[LEN_W];
      return t;
   endfunction

   pmg_state_e            state_q, state_d;
   logic [FLIT_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   acc_t                  acc_q, acc_d, acc_inc, first_bytes;
   logic [31:0]           sts_q, sts_d;
   pmg_meta_t             pend_q, pend_d, push_tok;
   logic                  pend_vld_q, pend_vld_d;
   logic [31:0]           ts_q, stats_pkt_q, stats_drop_q;
   logic [15:0]           pkt_id_q;
   logic                  run_q;
   logic                  out_vld_q, skid_vld_q;
   logic [FW-1:0]         out_flit_q, skid_flit_q, in_flit;
   logic                  in_acc, fwd, drop, push, out_pop;
   logic                  fifo_full, fifo_empty;
   logic [MAW:0]          meta_cnt;

   assign in_flit     = {in_pkt_data, in_pkt_sop, in_pkt_eop, in_pkt_empty};
   assign out_pop     = out_vld_q & out_pkt_ready;
   assign cnt_inc     = (cnt_q == FLIT_CNT_MAX) ? cnt_q : cnt_q + FLIT_CNT_W'(1);
   assign acc_inc     = add_flit_bytes(acc_q);
   assign first_bytes = add_flit_bytes('0);

   // run_q holds ready low for the first cycle out of reset. pend_vld_q stalls
   // ingress while a second token from the same flit waits for its FIFO slot.
   assign in_pkt_ready = run_q & ~skid_vld_q & ~pend_vld_q
                       & (meta_cnt != (MAW+1)'(META_DEPTH));
   assign in_acc       = in_pkt_valid & in_pkt_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      sts_d      = sts_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      fwd        = 1'b0;
      drop       = 1'b0;
      push       = 1'b0;
      push_tok   = '0;
      if (pend_vld_q) begin
         if (!fifo_full) begin
            push       = 1'b1;
            push_tok   = pend_q;
            pend_vld_d = 1'b0;
         end
      end else if (in_acc) begin
         unique case (state_q)
            IDLE: begin
               if (in_pkt_sop) begin
                  fwd   = 1'b1;
                  cnt_d = FLIT_CNT_W'(1);
                  acc_d = first_bytes;
                  sts_d = ts_q;
                  if (in_pkt_eop) begin
                     push     = 1'b1;
                     push_tok = make_tok(first_bytes, in_pkt_empty, FLIT_CNT_W'(1), ts_q, 1'b0);
                  end else begin
                     state_d = IN_PKT;
                  end
               end else begin
                  drop = 1'b1;
               end
            end
            IN_PKT: begin
               fwd = 1'b1;
               if (in_pkt_sop) begin
                  // Missing EOP: close the open packet as truncated, restart on this flit.
                  push     = 1'b1;
                  push_tok = make_tok(acc_q, '0, cnt_q, sts_q, 1'b1);
                  cnt_d    = FLIT_CNT_W'(1);
                  acc_d    = first_bytes;
                  sts_d    = ts_q;
                  if (in_pkt_eop) begin
                     pend_d     = make_tok(first_bytes, in_pkt_empty, FLIT_CNT_W'(1), ts_q, 1'b0);
                     pend_vld_d = 1'b1;
                     state_d    = IDLE;
                  end
               end else begin
                  cnt_d = cnt_inc;
                  acc_d = acc_inc;
                  if (in_pkt_eop) begin
                     push     = 1'b1;
                     push_tok = make_tok(acc_inc, in_pkt_empty, cnt_inc, sts_q, 1'b0);
                     state_d  = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      push_tok.pkt_id = pkt_id_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pend_vld_q   <= 1'b0;
         ts_q         <= '0;
         pkt_id_q     <= '0;
         stats_pkt_q  <= '0;
         stats_drop_q <= '0;
         run_q        <= 1'b0;
         out_vld_q    <= 1'b0;
         skid_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_vld_q <= pend_vld_d;
         ts_q       <= ts_q + 32'd1;
         run_q      <= 1'b1;
         if (push) begin
            pkt_id_q    <= pkt_id_q + 16'd1;
            stats_pkt_q <= stats_pkt_q + 32'd1;
         end
         if (drop) stats_drop_q <= stats_drop_q + 32'd1;
         // Output register refills from the skid entry first, then from ingress.
         if (!out_vld_q || out_pop) begin
            out_vld_q  <= skid_vld_q | fwd;
            skid_vld_q <= 1'b0;
         end else begin
            skid_vld_q <= skid_vld_q | fwd;
         end
      end
   end

   always_ff @(posedge clk) begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sts_q  <= sts_d;
      pend_q <= pend_d;
      if (!out_vld_q || out_pop) out_flit_q <= skid_vld_q ? skid_flit_q : in_flit;
      if (out_vld_q && !out_pop && !skid_vld_q) skid_flit_q <= in_flit;
   end

   assign {out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_empty} = out_flit_q;
   assign out_pkt_valid   = out_vld_q;
   assign out_meta_valid  = ~fifo_empty;
   assign stats_pkt       = stats_pkt_q;
   assign stats_drop_flit = stats_drop_q;

   pmg_sync_fifo #(
      .WIDTH ($bits(pmg_meta_t)),
      .DEPTH (META_DEPTH)
   ) u_meta_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (push),
      .wr_data_i (push_tok),
      .rd_en_i   (out_meta_ready),
      .rd_data_o (out_meta_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (meta_cnt)
   );

endmodule
